// File: rtl/register_bank.sv
// ============================================================================
// Module      : register_bank
// Description : 1W/2R register file with registered reads, optional
//               write-to-read bypass, and a sequenced one-entry-per-cycle clear.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module register_bank #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WRITEEN,
  input  logic [ADDR_W-1:0] INaddr,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1addr,
  input  logic [ADDR_W-1:0] OUT2addr,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              CLEAR,
  output logic              BUSY
);

  localparam int                C_DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(C_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;

  logic              w_wr_en;
  logic              w_clr_en;
  logic [DATA_W-1:0] w_mem [C_DEPTH];

  // Writes are only taken while idle; entry 0 swallows writes when hardwired.
  assign w_wr_en  = WRITEEN && (state_q == ST_IDLE) &&
                    !((ZERO_REG != 0) && (INaddr == '0));
  assign w_clr_en = (state_q == ST_CLEARING);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (CLEAR) begin
          state_d = ST_CLEARING;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEARING: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == C_LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage entries
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < C_DEPTH; i++) begin : g_entry
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign w_mem[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (w_clr_en && (cnt_q == ADDR_W'(i))) begin
          entry_d = '0;
        end else if (w_wr_en && (INaddr == ADDR_W'(i))) begin
          entry_d = IN;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign w_mem[i] = entry_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read ports; clear writes never feed the bypass
  // --------------------------------------------------------------------------
  always_comb begin
    out1_d = w_mem[OUT1addr];
    if ((BYPASS != 0) && w_wr_en && (OUT1addr == INaddr)) begin
      out1_d = IN;
    end
    if ((ZERO_REG != 0) && (OUT1addr == '0)) begin
      out1_d = '0;
    end

    out2_d = w_mem[OUT2addr];
    if ((BYPASS != 0) && w_wr_en && (OUT2addr == INaddr)) begin
      out2_d = IN;
    end
    if ((ZERO_REG != 0) && (OUT2addr == '0)) begin
      out2_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign OUT1 = out1_q;
  assign OUT2 = out2_q;
  assign BUSY = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_register_bank.sv
// ============================================================================
// Module      : tb_register_bank
// Description : Directed bench for register_bank in three parameter flavours.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_register_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [2:0] a1, a2;
  logic       clr;

  logic [7:0] o1_b, o2_b, o1_n, o2_n, o1_z, o2_z;
  logic       busy_b, busy_n, busy_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_bank #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .WRITEEN(we), .INaddr(wa), .IN(wd),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(o1_b), .OUT2(o2_b),
    .CLEAR(clr), .BUSY(busy_b)
  );

  register_bank #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
    .clk(clk), .reset(reset), .WRITEEN(we), .INaddr(wa), .IN(wd),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(o1_n), .OUT2(o2_n),
    .CLEAR(clr), .BUSY(busy_n)
  );

  register_bank #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .WRITEEN(we), .INaddr(wa), .IN(wd),
    .OUT1addr(a1), .OUT2addr(a2), .OUT1(o1_z), .OUT2(o2_z),
    .CLEAR(clr), .BUSY(busy_z)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;   // OUT1 of bypassing instances
    logic [7:0] e2;   // OUT2 of bypassing instance
    logic [7:0] n2;   // OUT2 of non-bypassing instance
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1;
      wa = 3'(i);
      wd = 8'(i + 1);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;

    vt[0] = '{1'b1, 3'd5, 8'd12,   3'd0, 3'd0, 8'd0,    8'd0,    8'd0};
    vt[1] = '{1'b0, 3'd0, 8'd0,    3'd5, 3'd3, 8'd12,   8'd0,    8'd0};
    vt[2] = '{1'b1, 3'd3, 8'd10,   3'd5, 3'd3, 8'd12,   8'd10,   8'd0};
    vt[3] = '{1'b0, 3'd0, 8'd0,    3'd5, 3'd3, 8'd12,   8'd10,   8'd10};
    vt[4] = '{1'b1, 3'd7, 8'h33,   3'd7, 3'd5, 8'h33,   8'd12,   8'd12};
    vt[5] = '{1'b1, 3'd7, 8'h44,   3'd7, 3'd7, 8'h44,   8'h44,   8'h33};
    vt[6] = '{1'b0, 3'd0, 8'd0,    3'd7, 3'd3, 8'h44,   8'd10,   8'd10};

    reset = 1'b1;
    we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0; clr = 1'b0;
    #2;
    check("rst_out1", o1_b, 0);
    check("rst_out2", o2_b, 0);
    check("rst_busy", busy_b, 0);
    check("rst_busy_n", busy_n, 0);
    check("rst_busy_z", busy_z, 0);
    tick();
    reset = 1'b0;

    // basic write/read and bypass behaviour
    foreach (vt[i]) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      a1 = vt[i].a1; a2 = vt[i].a2;
      tick();
      check($sformatf("vec%0d_out1", i), o1_b, vt[i].e1);
      check($sformatf("vec%0d_out2", i), o2_b, vt[i].e2);
      check($sformatf("vec%0d_out2_nobyp", i), o2_n, vt[i].n2);
      check($sformatf("vec%0d_out1_zreg", i), o1_z, vt[i].e1);
    end
    we = 1'b0;

    // full clear after ramp fill
    fill_ramp();
    a1 = 3'd7; a2 = 3'd0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy_rise", busy_b, 1);
    busy_cnt = busy_b ? 1 : 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (busy_b) busy_cnt++;
      check($sformatf("clr_rd7_e%0d", k), o1_b, 8);
      if (k == 1) begin
        check("clr_rd0_e1", o2_b, 1);
        check("clr_rd0_e1_zreg", o2_z, 0);
      end
      if (k == 2) check("clr_rd0_e2", o2_b, 0);
    end
    check("clr_busy_cycles", busy_cnt, 8);
    check("clr_busy_fall", busy_b, 0);
    check("clr_busy_fall_n", busy_n, 0);
    tick();
    check("clr_rd7_after", o1_b, 0);
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(7 - i);
      tick();
      check($sformatf("clr_zero_out1_%0d", i), o1_b, 0);
      check($sformatf("clr_zero_out2n_%0d", i), o2_n, 0);
    end

    // write together with clear, writes dropped while busy, clear re-request ignored
    we = 1'b1; wa = 3'd2; wd = 8'h11; a1 = 3'd4; a2 = 3'd2;
    tick();
    wa = 3'd4; wd = 8'h99; clr = 1'b1;
    tick();
    check("wclr_busy_rise", busy_b, 1);
    busy_cnt = busy_b ? 1 : 0;
    wa = 3'd2; wd = 8'hAA;
    for (int k = 1; k <= 8; k++) begin
      clr = (k == 4);
      tick();
      if (busy_b) busy_cnt++;
      if (k == 1) begin
        check("wclr_same_edge_write", o1_b, 8'h99);
        check("wclr_no_bypass", o2_b, 8'h11);
      end
      if (k == 4) check("wclr_rd2_cleared", o2_n, 0);
    end
    clr = 1'b0; we = 1'b0;
    check("wclr_busy_cycles", busy_cnt, 8);
    check("wclr_busy_fall", busy_b, 0);
    tick();
    check("wclr_rd4_zero", o1_b, 0);
    check("wclr_rd2_dropped", o2_b, 0);

    // CLEAR held high: one idle cycle between back-to-back clears
    clr = 1'b1;
    tick();
    check("hold_busy_first", busy_b, 1);
    repeat (7) tick();
    check("hold_busy_last", busy_b, 1);
    tick();
    check("hold_busy_gap", busy_b, 0);
    tick();
    check("hold_busy_restart", busy_b, 1);
    clr = 1'b0;
    repeat (8) tick();
    check("hold_busy_end", busy_b, 0);

    // hardwired zero entry
    we = 1'b1; wa = 3'd0; wd = 8'h55; a1 = 3'd0;
    tick();
    check("zreg_bypass_supp", o1_z, 0);
    check("zreg_ref_bypass", o1_b, 8'h55);
    check("zreg_ref_nobyp_old", o1_n, 0);
    we = 1'b0;
    tick();
    check("zreg_read_after", o1_z, 0);
    check("zreg_ref_nobyp_new", o1_n, 8'h55);

    // asynchronous reset in the middle of a clear
    fill_ramp();
    a1 = 3'd7; a2 = 3'd6;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    check("arst_pre_out1", o1_b, 8);
    check("arst_pre_out2", o2_b, 7);
    check("arst_pre_busy", busy_b, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out1", o1_b, 0);
    check("arst_out2", o2_b, 0);
    check("arst_busy", busy_b, 0);
    check("arst_busy_z", busy_z, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(i);
      tick();
      check($sformatf("arst_zero_out1_%0d", i), o1_b, 0);
      check($sformatf("arst_zero_out2n_%0d", i), o2_n, 0);
      check($sformatf("arst_zero_out1z_%0d", i), o1_z, 0);
    end
    check("arst_busy_after", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
